// File: rtl/alu_pkg.sv
// alu_pkg: shared datapath width and ALU opcode constants
package alu_pkg;
  localparam int PROC_BITS = 32;
  localparam int SHAMT_BITS = $clog2(PROC_BITS);
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_NOR = 4'b0101;
  localparam logic [3:0] OP_SLT = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b0111;
  localparam logic [3:0] OP_SRL = 4'b1000;
  localparam logic [3:0] OP_SRA = 4'b1001;
  localparam logic [3:0] OP_LUI = 4'b1010;
endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: combinational SLL/SRL/SRA/LUI of operand b (other ops yield 0)
module alu_shifter
  import alu_pkg::*;
(
  input  logic [PROC_BITS-1:0]  b,
  input  logic [SHAMT_BITS-1:0] shamt,
  input  logic [3:0]            op,
  output logic [PROC_BITS-1:0]  y
);
  localparam int H = PROC_BITS / 2;
  // select the shift flavour; LUI moves the low half of b into the high half
  always_comb
    y = (op == OP_SLL) ? b << shamt :
        (op == OP_SRL) ? b >> shamt :
        (op == OP_SRA) ? PROC_BITS'($signed(b) >>> shamt) :
        (op == OP_LUI) ? {b[H-1:0], {H{1'b0}}} :
        '0;
endmodule

// File: rtl/proc_alu.sv
// proc_alu: execute-stage integer ALU, 1-cycle registered result (optional o_zero via ALU_ZERO_FLAG_EN)
module proc_alu
  import alu_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic [PROC_BITS-1:0] i_dataA,
  input  logic [PROC_BITS-1:0] i_dataB,
  input  logic [3:0]           i_operation,
  output logic [PROC_BITS-1:0] o_result,
  output logic                 o_valid
`ifdef ALU_ZERO_FLAG_EN
  ,
  output logic                 o_zero
`endif
);
  logic [PROC_BITS-1:0] sh, res;
  logic lt;
  alu_shifter u_shifter (
    .b     (i_dataB),
    .shamt (i_dataA[SHAMT_BITS-1:0]),
    .op    (i_operation),
    .y     (sh)
  );
  assign lt = $signed(i_dataA) < $signed(i_dataB);
  // arithmetic/logic/compare mux; shifts and LUI come from the shifter
  always_comb begin
    res = '0;
    case (i_operation)
      OP_ADD:                         res = i_dataA + i_dataB;
      OP_SUB:                         res = i_dataA - i_dataB;
      OP_AND:                         res = i_dataA & i_dataB;
      OP_OR:                          res = i_dataA | i_dataB;
      OP_XOR:                         res = i_dataA ^ i_dataB;
      OP_NOR:                         res = ~(i_dataA | i_dataB);
      OP_SLT:                         res = {{(PROC_BITS-1){1'b0}}, lt};
      OP_SLL, OP_SRL, OP_SRA, OP_LUI: res = sh;
      default:                        res = '0;
    endcase
  end
  // result register: loads on valid, holds otherwise
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      o_result <= '0;
      o_valid  <= 1'b0;
    end else begin
      o_valid <= i_valid;
      if (i_valid) o_result <= res;
    end
`ifdef ALU_ZERO_FLAG_EN
  // zero flag tracks the registered result under the same load rules
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) o_zero <= 1'b0;
    else if (i_valid) o_zero <= (res == '0);
`endif
endmodule

// File: tb/tb_proc_alu.sv
// tb_proc_alu: directed self-checking bench for proc_alu
module tb_proc_alu;
  import alu_pkg::*;
  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 valid = 1'b0;
  logic [PROC_BITS-1:0] a = '0;
  logic [PROC_BITS-1:0] b = '0;
  logic [3:0]           opc = '0;
  logic [PROC_BITS-1:0] result;
  logic                 ovalid;
  int n_cmp = 0;
  int n_bad = 0;
`ifdef ALU_ZERO_FLAG_EN
  logic zero;
`endif
  proc_alu dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_valid     (valid),
    .i_dataA     (a),
    .i_dataB     (b),
    .i_operation (opc),
    .o_result    (result),
    .o_valid     (ovalid)
`ifdef ALU_ZERO_FLAG_EN
    ,
    .o_zero      (zero)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk_res(input string tag, input logic [PROC_BITS-1:0] e);
    n_cmp++;
    assert (result === e) else begin
      n_bad++;
      $error("FAIL %s result=%h expected=%h", tag, result, e);
    end
  endtask
  task automatic chk_vld(input string tag, input logic e);
    n_cmp++;
    assert (ovalid === e) else begin
      n_bad++;
      $error("FAIL %s valid=%b expected=%b", tag, ovalid, e);
    end
  endtask
`ifdef ALU_ZERO_FLAG_EN
  task automatic chk_zero(input string tag, input logic e);
    n_cmp++;
    assert (zero === e) else begin
      n_bad++;
      $error("FAIL %s zero=%b expected=%b", tag, zero, e);
    end
  endtask
`endif
  task automatic run(input string tag, input logic [3:0] o, input logic [PROC_BITS-1:0] x,
                     input logic [PROC_BITS-1:0] y, input logic [PROC_BITS-1:0] e);
    @(negedge clk);
    valid = 1'b1;
    opc = o;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    chk_vld(tag, 1'b1);
    chk_res(tag, e);
`ifdef ALU_ZERO_FLAG_EN
    chk_zero(tag, e == '0);
`endif
  endtask
  initial begin
    #1;
    chk_res("reset_result", '0);
    chk_vld("reset_valid", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run("add_neg", OP_ADD, 32'hFFFFFFC9, 32'd8, 32'hFFFFFFD1);
    @(negedge clk);
    opc = OP_ADD;
    a = 32'd1;
    b = 32'd2;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_res("async_rst_result", '0);
    chk_vld("async_rst_valid", 1'b0);
`ifdef ALU_ZERO_FLAG_EN
    chk_zero("async_rst_zero", 1'b0);
`endif
    @(posedge clk);
    #1;
    chk_res("rst_hold_result", '0);
    chk_vld("rst_hold_valid", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run("sub", OP_SUB, 32'd40, 32'd50, 32'hFFFFFFF6);
    run("sub_wrap", OP_SUB, 32'h0, 32'd1, 32'hFFFFFFFF);
    run("and", OP_AND, 32'd40, 32'd50, 32'd32);
    run("or", OP_OR, 32'd40, 32'd50, 32'd58);
    run("xor", OP_XOR, 32'd40, 32'd50, 32'd26);
    run("nor", OP_NOR, 32'd40, 32'd50, 32'hFFFFFFC5);
    run("slt_lt", OP_SLT, 32'd40, 32'd50, 32'd1);
    run("slt_gt", OP_SLT, 32'd60, 32'd50, 32'd0);
    run("slt_neg", OP_SLT, 32'hFFFFFFFF, 32'd1, 32'd1);
    run("slt_eq", OP_SLT, 32'd5, 32'd5, 32'd0);
    run("slt_minmax", OP_SLT, 32'h80000000, 32'h7FFFFFFF, 32'd1);
    run("slt_maxmin", OP_SLT, 32'h7FFFFFFF, 32'h80000000, 32'd0);
    run("sll", OP_SLL, 32'd5, 32'd40, 32'd1280);
    run("srl", OP_SRL, 32'd5, 32'd40, 32'd1);
    run("sra_pos", OP_SRA, 32'd5, 32'd85, 32'd2);
    run("sra_neg", OP_SRA, 32'd5, 32'hFFFFFFAB, 32'hFFFFFFFD);
    run("srl_neg", OP_SRL, 32'd5, 32'hFFFFFFAB, 32'h07FFFFFD);
    run("sll_upper", OP_SLL, 32'h25, 32'd1, 32'd32);
    run("sra_zero", OP_SRA, 32'h0, 32'h80000001, 32'h80000001);
    run("srl_31", OP_SRL, 32'd31, 32'h80000000, 32'd1);
    run("lui", OP_LUI, 32'hDEADBEEF, 32'd61, 32'h003D0000);
    run("op_1111", 4'b1111, 32'd40, 32'd50, 32'd0);
    run("op_1011", 4'b1011, 32'd40, 32'd50, 32'd0);
    run("sub_zero", OP_SUB, 32'd7, 32'd7, 32'd0);
    run("add_post", OP_ADD, 32'd3, 32'd4, 32'd7);
    @(negedge clk);
    valid = 1'b0;
    opc = OP_SUB;
    a = 32'd9;
    b = 32'd9;
    @(posedge clk);
    #1;
    chk_vld("idle_valid", 1'b0);
    chk_res("idle_hold", 32'd7);
`ifdef ALU_ZERO_FLAG_EN
    chk_zero("idle_zero_hold", 1'b0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
